// File: rtl/iir_axis_pkg.sv
// iir_axis_pkg: sample type and width helper shared by the biquad and decimator stages
package iir_axis_pkg;
   localparam int SAMPLE_W = 16;
   typedef logic signed [SAMPLE_W-1:0] sample_t;
   function automatic int level_w(input int depth);
      return $clog2(depth) + 1;
   endfunction
endpackage

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: first-word-fall-through FIFO with separate level counter
// Ports: clk, rst_n (async active-low); i_push/i_data write side; i_pop read side;
//        o_data head word (raw, ungated); o_level occupancy; o_full/o_empty flags.
module sync_fifo_fwft
   import iir_axis_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      i_push,
   input  logic                      i_pop,
   input  logic [DATA_W-1:0]         i_data,
   output logic [DATA_W-1:0]         o_data,
   output logic [level_w(DEPTH)-1:0] o_level,
   output logic                      o_full,
   output logic                      o_empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = level_w(DEPTH);
   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [LW-1:0]     r_level;
   always_ff @(posedge clk)
      if (i_push) r_mem[r_wr_ptr] <= i_data;
   // pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (i_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
         if (i_push != i_pop) r_level <= i_push ? r_level + 1'b1 : r_level - 1'b1;
      end
   assign o_data  = r_mem[r_rd_ptr];
   assign o_level = r_level;
   assign o_full  = r_level == LW'(DEPTH);
   assign o_empty = r_level == '0;
endmodule

// File: rtl/axis_decim_fifo.sv
// axis_decim_fifo: keep one of every DECIM samples and buffer them toward an AXI-Stream master
// Ports: clk, rst_n (async active-low); s_axis_* strobe-style input (tready advisory);
//        m_axis_* AXI-Stream output with backpressure; fifo_level occupancy;
//        ovf sticky overflow flag, cleared by ovf_clr.
module axis_decim_fifo
   import iir_axis_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int DECIM  = 4,
   parameter int DEPTH  = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      s_axis_tvalid,
   input  logic [DATA_W-1:0]         s_axis_tdata,
   output logic                      s_axis_tready,
   output logic                      m_axis_tvalid,
   output logic [DATA_W-1:0]         m_axis_tdata,
   input  logic                      m_axis_tready,
   output logic [level_w(DEPTH)-1:0] fifo_level,
   output logic                      ovf,
   input  logic                      ovf_clr
);
   localparam int PW = DECIM > 1 ? $clog2(DECIM) : 1;
   logic [PW-1:0]     r_phase;
   logic              r_ovf;
   logic              w_keep;
   logic              w_pop;
   logic              w_push;
   logic              w_drop;
   logic              w_full;
   logic              w_empty;
   logic [DATA_W-1:0] w_head;
   assign w_keep = s_axis_tvalid && r_phase == '0;
   assign w_pop  = !w_empty && m_axis_tready;
   // a full FIFO still accepts when the head leaves in the same cycle
   assign w_push = w_keep && (!w_full || w_pop);
   assign w_drop = w_keep && !w_push;
   // phase advances on every strobe, stored or dropped, so decimation stays time-aligned
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_phase <= '0;
         r_ovf   <= 1'b0;
      end else begin
         if (s_axis_tvalid) r_phase <= r_phase == PW'(DECIM - 1) ? '0 : r_phase + 1'b1;
         if (w_drop) r_ovf <= 1'b1;
         else if (ovf_clr) r_ovf <= 1'b0;
      end
   sync_fifo_fwft #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (s_axis_tdata),
      .o_data  (w_head),
      .o_level (fifo_level),
      .o_full  (w_full),
      .o_empty (w_empty)
   );
   assign s_axis_tready = !w_full;
   assign m_axis_tvalid = !w_empty;
   assign m_axis_tdata  = w_empty ? '0 : w_head;
   assign ovf           = r_ovf;
endmodule

// File: tb/tb_axis_decim_fifo.sv
// tb_axis_decim_fifo: directed and randomized checks of two decimator instances (DECIM=4 and DECIM=1)
module tb_axis_decim_fifo;
   import iir_axis_pkg::*;
   localparam int DEPTH = 16;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   logic v4 = 0, r4 = 1, c4 = 0, sr4, mv4, o4;
   logic v1 = 0, r1 = 1, c1 = 0, sr1, mv1, o1;
   sample_t d4 = '0, d1 = '0, md4, md1;
   logic [4:0] l4, l1;
   int n_cmp = 0, n_bad = 0;
   axis_decim_fifo #(.DATA_W(16), .DECIM(4), .DEPTH(DEPTH)) u_d4 (
      .clk(clk), .rst_n(rst_n), .s_axis_tvalid(v4), .s_axis_tdata(d4), .s_axis_tready(sr4),
      .m_axis_tvalid(mv4), .m_axis_tdata(md4), .m_axis_tready(r4), .fifo_level(l4),
      .ovf(o4), .ovf_clr(c4));
   axis_decim_fifo #(.DATA_W(16), .DECIM(1), .DEPTH(DEPTH)) u_d1 (
      .clk(clk), .rst_n(rst_n), .s_axis_tvalid(v1), .s_axis_tdata(d1), .s_axis_tready(sr1),
      .m_axis_tvalid(mv1), .m_axis_tdata(md1), .m_axis_tready(r1), .fifo_level(l1),
      .ovf(o1), .ovf_clr(c1));
   // reference: a sample count decides keeping, a queue holds stored samples
   sample_t q4[$], q1[$];
   int n4 = 0, n1 = 0;
   bit ovf_m4 = 0, ovf_m1 = 0;
   bit pop4, keep4, put4, pop1, keep1, put1;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q4.delete(); n4 = 0; ovf_m4 = 0;
         q1.delete(); n1 = 0; ovf_m1 = 0;
      end else begin
         pop4 = q4.size() != 0 && r4;
         keep4 = v4 && (n4 % 4) == 0;
         if (v4) n4++;
         if (pop4) void'(q4.pop_front());
         put4 = keep4 && q4.size() < DEPTH;
         if (put4) q4.push_back(d4);
         if (keep4 && !put4) ovf_m4 = 1; else if (c4) ovf_m4 = 0;
         pop1 = q1.size() != 0 && r1;
         keep1 = v1;
         if (v1) n1++;
         if (pop1) void'(q1.pop_front());
         put1 = keep1 && q1.size() < DEPTH;
         if (put1) q1.push_back(d1);
         if (keep1 && !put1) ovf_m1 = 1; else if (c1) ovf_m1 = 0;
      end
   end
   sample_t fill_q[$];

   task automatic test_reset();
      rst_n = 0; v4 = 0; v1 = 0; r4 = 1; r1 = 1; c4 = 0; c1 = 0;
      repeat (3) @(negedge clk);
      n_cmp++; if (mv4 !== 1'b0) begin n_bad++; $display("FAIL reset_tvalid4 got %b want 0", mv4); end
      n_cmp++; if (md4 !== 16'sd0) begin n_bad++; $display("FAIL reset_tdata4 got %0d want 0", md4); end
      n_cmp++; if (l4 !== 5'd0) begin n_bad++; $display("FAIL reset_level4 got %0d want 0", l4); end
      n_cmp++; if (o4 !== 1'b0) begin n_bad++; $display("FAIL reset_ovf4 got %b want 0", o4); end
      n_cmp++; if (sr4 !== 1'b1) begin n_bad++; $display("FAIL reset_sready4 got %b want 1", sr4); end
      n_cmp++; if ({mv1, md1, l1, o1, sr1} !== {1'b0, 16'd0, 5'd0, 1'b0, 1'b1})
         begin n_bad++; $display("FAIL reset_d1 got v%b d%0d l%0d o%b r%b want v0 d0 l0 o0 r1", mv1, md1, l1, o1, sr1); end
      rst_n = 1;
      @(negedge clk);
   endtask

   task automatic test_decimation();
      int outs = 0, kept = 0, val;
      for (int n = 1; n <= 12; n++) begin
         val = (n % 2) ? 100 * n : -100 * n;
         if (mv4) outs++;
         v4 = 1; d4 = sample_t'(val);
         @(negedge clk);
         v4 = 0;
         if ((n - 1) % 4 == 0) begin
            kept++;
            n_cmp++; if (mv4 !== 1'b1 || md4 !== sample_t'(val))
               begin n_bad++; $display("FAIL decim_out%0d got v%b %0d want v1 %0d", kept, mv4, md4, val); end
         end
         if (mv4) outs++;
         repeat (3) begin @(negedge clk); if (mv4) outs++; end
      end
      n_cmp++; if (outs != 3) begin n_bad++; $display("FAIL decim_count got %0d want 3", outs); end
   endtask

   task automatic test_backpressure();
      fill_q.delete();
      r1 = 0;
      for (int i = 0; i < DEPTH; i++) begin
         v1 = 1; d1 = sample_t'($urandom); fill_q.push_back(d1);
         @(negedge clk);
      end
      v1 = 0;
      n_cmp++; if (l1 !== 5'd16) begin n_bad++; $display("FAIL full_level got %0d want 16", l1); end
      n_cmp++; if (sr1 !== 1'b0) begin n_bad++; $display("FAIL full_sready got %b want 0", sr1); end
      n_cmp++; if (mv1 !== 1'b1 || md1 !== fill_q[0])
         begin n_bad++; $display("FAIL full_head got v%b %0d want v1 %0d", mv1, md1, fill_q[0]); end
   endtask

   task automatic test_overflow();
      v1 = 1; d1 = 16'sh7fff;
      @(negedge clk);
      v1 = 0;
      n_cmp++; if (o1 !== 1'b1) begin n_bad++; $display("FAIL ovf_set got %b want 1", o1); end
      n_cmp++; if (l1 !== 5'd16) begin n_bad++; $display("FAIL ovf_level got %0d want 16", l1); end
      v1 = 1; d1 = -16'sd1; c1 = 1;
      @(negedge clk);
      v1 = 0; c1 = 0;
      n_cmp++; if (o1 !== 1'b1) begin n_bad++; $display("FAIL ovf_set_wins got %b want 1", o1); end
      c1 = 1;
      @(negedge clk);
      c1 = 0;
      n_cmp++; if (o1 !== 1'b0) begin n_bad++; $display("FAIL ovf_clear got %b want 0", o1); end
      r1 = 1;
      for (int i = 0; i < DEPTH; i++) begin
         n_cmp++; if (mv1 !== 1'b1 || md1 !== fill_q[i])
            begin n_bad++; $display("FAIL drain%0d got v%b %0d want v1 %0d", i, mv1, md1, fill_q[i]); end
         @(negedge clk);
      end
      n_cmp++; if (mv1 !== 1'b0 || l1 !== 5'd0) begin n_bad++; $display("FAIL drain_empty got v%b l%0d want v0 l0", mv1, l1); end
   endtask

   task automatic test_push_pop_full();
      fill_q.delete();
      r1 = 0;
      for (int i = 0; i < DEPTH; i++) begin
         v1 = 1; d1 = sample_t'($urandom); fill_q.push_back(d1);
         @(negedge clk);
      end
      n_cmp++; if (l1 !== 5'd16 || md1 !== fill_q[0])
         begin n_bad++; $display("FAIL pp_full got l%0d %0d want l16 %0d", l1, md1, fill_q[0]); end
      r1 = 1; v1 = 1; d1 = -16'sd32768;
      void'(fill_q.pop_front());
      fill_q.push_back(-16'sd32768);
      @(negedge clk);
      v1 = 0;
      n_cmp++; if (l1 !== 5'd16) begin n_bad++; $display("FAIL pp_level got %0d want 16", l1); end
      n_cmp++; if (o1 !== 1'b0) begin n_bad++; $display("FAIL pp_ovf got %b want 0", o1); end
      for (int i = 0; i < DEPTH; i++) begin
         n_cmp++; if (mv1 !== 1'b1 || md1 !== fill_q[i])
            begin n_bad++; $display("FAIL pp_drain%0d got v%b %0d want v1 %0d", i, mv1, md1, fill_q[i]); end
         @(negedge clk);
      end
      n_cmp++; if (mv1 !== 1'b0) begin n_bad++; $display("FAIL pp_empty got v%b want v0", mv1); end
   endtask

   task automatic test_reset_mid();
      r1 = 0;
      repeat (5) begin v1 = 1; d1 = sample_t'($urandom); @(negedge clk); end
      v1 = 0;
      n_cmp++; if (l1 !== 5'd5) begin n_bad++; $display("FAIL mid_level got %0d want 5", l1); end
      #2 rst_n = 0;
      #1;
      n_cmp++; if ({mv1, md1, l1, sr1} !== {1'b0, 16'd0, 5'd0, 1'b1})
         begin n_bad++; $display("FAIL mid_async got v%b d%0d l%0d r%b want v0 d0 l0 r1", mv1, md1, l1, sr1); end
      @(negedge clk);
      rst_n = 1; r1 = 1; r4 = 1;
      @(negedge clk);
      v1 = 1; d1 = 16'sd42; v4 = 1; d4 = 16'sd42;
      @(negedge clk);
      v1 = 0; v4 = 0;
      n_cmp++; if (mv1 !== 1'b1 || md1 !== 16'sd42) begin n_bad++; $display("FAIL mid_first1 got v%b %0d want v1 42", mv1, md1); end
      n_cmp++; if (mv4 !== 1'b1 || md4 !== 16'sd42) begin n_bad++; $display("FAIL mid_first4 got v%b %0d want v1 42", mv4, md4); end
   endtask

   task automatic test_random();
      sample_t e4, e1;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         e4 = q4.size() != 0 ? q4[0] : '0;
         e1 = q1.size() != 0 ? q1[0] : '0;
         n_cmp++; if ({mv4, md4, l4, o4, sr4} !== {q4.size() != 0, e4, 5'(q4.size()), ovf_m4, q4.size() != DEPTH})
            begin n_bad++; $display("FAIL rand4 cyc%0d got v%b d%0d l%0d o%b r%b want v%b d%0d l%0d o%b r%b", cyc,
               mv4, md4, l4, o4, sr4, q4.size() != 0, e4, q4.size(), ovf_m4, q4.size() != DEPTH); end
         n_cmp++; if ({mv1, md1, l1, o1, sr1} !== {q1.size() != 0, e1, 5'(q1.size()), ovf_m1, q1.size() != DEPTH})
            begin n_bad++; $display("FAIL rand1 cyc%0d got v%b d%0d l%0d o%b r%b want v%b d%0d l%0d o%b r%b", cyc,
               mv1, md1, l1, o1, sr1, q1.size() != 0, e1, q1.size(), ovf_m1, q1.size() != DEPTH); end
         v4 = $urandom_range(0, 1) == 0; d4 = sample_t'($urandom);
         v1 = $urandom_range(0, 2) == 0; d1 = sample_t'($urandom);
         r4 = $urandom_range(0, 99) < (((cyc / 150) % 2) ? 5 : 70);
         r1 = $urandom_range(0, 99) < (((cyc / 100) % 2) ? 10 : 60);
         c4 = $urandom_range(0, 19) == 0;
         c1 = $urandom_range(0, 19) == 0;
         @(negedge clk);
      end
      v4 = 0; v1 = 0; c4 = 0; c1 = 0;
   endtask

   initial begin
      test_reset();
      test_decimation();
      test_backpressure();
      test_overflow();
      test_push_pop_full();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
